// File: rtl/spi_pkg.sv
// Shared types and width helpers for the multi-slave SPI master.
// Contents: FSM state enum, per-transfer mode struct, counter-width functions.
// No ports; imported by spi_clkgen and spi_master_multi.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        XFER  = 2'd2,
        TRAIL = 2'd3
    } state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // Divider counter runs 0..CLKDIV-1.
    function automatic int div_cnt_w(input int clkdiv);
        return $clog2(clkdiv + 1);
    endfunction

    // Edge counter runs 0..2*DW-1.
    function automatic int bit_cnt_w(input int dw);
        return $clog2(2 * dw + 1);
    endfunction

endpackage

// File: rtl/spi_clkgen.sv
// SCLK generator: toggles SCLK every CLKDIV cycles while enabled, idles at idle_lvl.
// Ports: clk/rst, en (XFER), idle_lvl (CPOL), sclk, lead_edge/trail_edge strobes.
// The edge strobes are high in the cycle before SCLK changes, so the FSM acts on
// the same clock edge that moves SCLK.
module spi_clkgen
    import spi_pkg::*;
#(
    parameter int CLKDIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic idle_lvl,
    output logic sclk,
    output logic lead_edge,
    output logic trail_edge
);

    localparam int DIV_W = div_cnt_w(CLKDIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             sclk_q, sclk_d;
    logic             tick;

    always_comb begin
        tick       = en && (div_q == DIV_LAST);
        div_d      = '0;
        sclk_d     = idle_lvl;
        if (en) begin
            div_d  = tick ? '0 : div_q + DIV_W'(1);
            sclk_d = tick ? ~sclk_q : sclk_q;
        end
        // SCLK at idle level means the next toggle is the leading edge.
        lead_edge  = tick && (sclk_q == idle_lvl);
        trail_edge = tick && (sclk_q != idle_lvl);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk = sclk_q;

endmodule

// File: rtl/spi_master_multi.sv
// Parametrised full-duplex SPI master, MSB first, per-transfer CPOL/CPHA, NSS selects.
// Ports: Strobe_i/Busy_o/Ready_o handshake, Buf_i/Rcvd_o data, Ss_i mask, SPI pins.
// Strobes are honoured only in IDLE with a non-zero mask; there is no queueing.
module spi_master_multi
    import spi_pkg::*;
#(
    parameter int DW     = 8,
    parameter int NSS    = 2,
    parameter int CLKDIV = 2
) (
    input  logic           Clk_i,
    input  logic           Rst_i,
    input  logic [DW-1:0]  Buf_i,
    input  logic [NSS-1:0] Ss_i,
    input  logic           Cpol_i,
    input  logic           Cpha_i,
    input  logic           Strobe_i,
    output logic           Busy_o,
    output logic           Ready_o,
    output logic [DW-1:0]  Rcvd_o,
    output logic           Sclk_o,
    output logic           Mosi_o,
    input  logic           Miso_i,
    output logic [NSS-1:0] Ss_no
);

    localparam int DIV_W = div_cnt_w(CLKDIV);
    localparam int BIT_W = bit_cnt_w(DW);
    localparam logic [DIV_W-1:0] PH_LAST  = DIV_W'(CLKDIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * DW - 1);

    state_t           state_q, state_d;
    spi_mode_t        mode_q, mode_d;
    logic [DW-1:0]    tx_q, tx_d;
    logic [DW-1:0]    rx_q, rx_d;
    logic [DW-1:0]    rcvd_q, rcvd_d;
    logic [NSS-1:0]   ss_n_q, ss_n_d;
    logic             mosi_q, mosi_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic [DIV_W-1:0] phase_q, phase_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic             lead_edge, trail_edge;

    // Idle level follows the next-cycle mode so SCLK settles to the new CPOL
    // on the acceptance edge rather than one cycle into LEAD.
    spi_clkgen #(.CLKDIV(CLKDIV)) u_clkgen (
        .clk        (Clk_i),
        .rst        (Rst_i),
        .en         (state_q == XFER),
        .idle_lvl   (mode_d.cpol),
        .sclk       (Sclk_o),
        .lead_edge  (lead_edge),
        .trail_edge (trail_edge)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rcvd_d  = rcvd_q;
        ss_n_d  = ss_n_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        ready_d = 1'b0;
        phase_d = phase_q;
        bit_d   = bit_q;

        unique case (state_q)
            IDLE: begin
                if (Strobe_i && (Ss_i != '0)) begin
                    state_d = LEAD;
                    mode_d  = '{cpol: Cpol_i, cpha: Cpha_i};
                    tx_d    = Buf_i;
                    rx_d    = '0;
                    ss_n_d  = ~Ss_i;
                    busy_d  = 1'b1;
                    phase_d = '0;
                    bit_d   = '0;
                    // CPHA=0 slaves sample on the first edge, so the MSB must
                    // already be on the wire during LEAD.
                    if (!Cpha_i) begin
                        mosi_d = Buf_i[DW-1];
                    end
                end
            end
            LEAD: begin
                if (phase_q == PH_LAST) begin
                    state_d = XFER;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + DIV_W'(1);
                end
            end
            XFER: begin
                if (lead_edge) begin
                    if (mode_q.cpha) begin
                        mosi_d = tx_q[DW-1];
                        tx_d   = tx_q << 1;
                    end else begin
                        rx_d   = {rx_q[DW-2:0], Miso_i};
                    end
                end
                if (trail_edge) begin
                    if (mode_q.cpha) begin
                        rx_d = {rx_q[DW-2:0], Miso_i};
                    end else if (bit_q != BIT_LAST) begin
                        // MSB was presented in LEAD, so each trailing edge
                        // brings out the bit after the current one.
                        mosi_d = tx_q[DW-2];
                        tx_d   = tx_q << 1;
                    end
                end
                if (lead_edge || trail_edge) begin
                    bit_d = bit_q + BIT_W'(1);
                end
                if (trail_edge && (bit_q == BIT_LAST)) begin
                    state_d = TRAIL;
                    phase_d = '0;
                end
            end
            TRAIL: begin
                if (phase_q == PH_LAST) begin
                    state_d = IDLE;
                    ss_n_d  = '1;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    rcvd_d  = rx_q;
                end else begin
                    phase_d = phase_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            state_q <= IDLE;
            mode_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rcvd_q  <= '0;
            ss_n_q  <= '1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            phase_q <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rcvd_q  <= rcvd_d;
            ss_n_q  <= ss_n_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
        end
    end

    assign Busy_o  = busy_q;
    assign Ready_o = ready_q;
    assign Rcvd_o  = rcvd_q;
    assign Mosi_o  = mosi_q;
    assign Ss_no   = ss_n_q;

endmodule
